frame_bank_buffer: RTL and testbench

Parametrised multi-bank frame buffer for the FEC encoder datapath, generalising the two-bank ping-pong buffer to BANKS banks of DEPTH words with variable-length frames. The writer fills one bank at a time and commits it as a frame, either on the DEPTH-th word or on an explicit `wr_last`. The reader drains committed frames in commit order with a 1-cycle registered read and a last-word marker. It sits between the message source and the encoder core, decoupling bursty input from per-frame encoding.

---
 rtl/frame_bank_buffer.sv | 138 +++++++++++++
 tb/tb_frame_bank_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_buffer.sv
// BANKS-deep bank buffer: writer fills/commits whole frames, reader drains them in commit order.
// Optional sticky error flags when FRAME_BUF_ERR_EN is defined; otherwise err_* are tied low.
module frame_bank_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int BANKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_last,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         rd_valid,
  output logic                         rd_last,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(BANKS+1)-1:0]   frames_ready,
  output logic                         err_overflow,
  output logic                         err_underflow
);
  localparam int BW = $clog2(BANKS);
  localparam int CW = $clog2(DEPTH);
  localparam int FW = $clog2(BANKS+1);

  logic [WIDTH-1:0] mem [BANKS][DEPTH];

  logic [BW-1:0]    wbank_q, wbank_d, rbank_q, rbank_d;
  logic [CW-1:0]    wcount_q, wcount_d, rcount_q, rcount_d;
  // Frame length is stored as (length - 1) so it fits in the index width.
  logic [CW-1:0]    len_q [BANKS];
  logic [CW-1:0]    len_d [BANKS];
  logic [FW-1:0]    frames_q, frames_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             wr_acc, rd_acc, wr_close, rd_close;

  assign full         = (frames_q == FW'(BANKS));
  assign empty        = (frames_q == '0);
  assign frames_ready = frames_q;
  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;

  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_close = wr_acc && (wr_last || (wcount_q == CW'(DEPTH-1)));
    rd_close = rd_acc && (rcount_q == len_q[rbank_q]);

    wbank_d    = wbank_q;
    wcount_d   = wcount_q;
    rbank_d    = rbank_q;
    rcount_d   = rcount_q;
    len_d      = len_q;
    frames_d   = frames_q;
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;
    rd_last_d  = rd_close;

    if (wr_close) begin
      len_d[wbank_q] = wcount_q;
      wcount_d       = '0;
      wbank_d        = (wbank_q == BW'(BANKS-1)) ? '0 : wbank_q + BW'(1);
    end else if (wr_acc) begin
      wcount_d = wcount_q + CW'(1);
    end

    if (rd_acc) data_out_d = mem[rbank_q][rcount_q];
    if (rd_close) begin
      rcount_d = '0;
      rbank_d  = (rbank_q == BW'(BANKS-1)) ? '0 : rbank_q + BW'(1);
    end else if (rd_acc) begin
      rcount_d = rcount_q + CW'(1);
    end

    case ({wr_close, rd_close})
      2'b10:   frames_d = frames_q + FW'(1);
      2'b01:   frames_d = frames_q - FW'(1);
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wbank_q][wcount_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q    <= '0;
      wcount_q   <= '0;
      rbank_q    <= '0;
      rcount_q   <= '0;
      frames_q   <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      for (int b = 0; b < BANKS; b++) len_q[b] <= '0;
    end else begin
      wbank_q    <= wbank_d;
      wcount_q   <= wcount_d;
      rbank_q    <= rbank_d;
      rcount_q   <= rcount_d;
      frames_q   <= frames_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      len_q      <= len_d;
    end
  end

`ifdef FRAME_BUF_ERR_EN
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (wr_en && full);
    err_udf_d = err_udf_q | (rd_en && empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_frame_bank_buffer.sv
// Scoreboard bench for frame_bank_buffer at WIDTH=8, DEPTH=4, BANKS=2.
module tb_frame_bank_buffer;
`ifdef FRAME_BUF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_last, rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid, rd_last, full, empty;
  logic [1:0] frames_ready;
  logic       err_overflow, err_underflow;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb [$];

  frame_bank_buffer #(.WIDTH(8), .DEPTH(4), .BANKS(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_last(wr_last), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .rd_last(rd_last),
    .full(full), .empty(empty), .frames_ready(frames_ready),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Every valid read word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got data=%02h last=%0b, expected no output", data_out, rd_last);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({rd_last, data_out} !== e) begin
          errors++;
          $display("FAIL read_word: got data=%02h last=%0b, expected data=%02h last=%0b",
                   data_out, rd_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic l, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_en = w; wr_last = l; data_in = d; rd_en = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic read_word(input logic [7:0] d, input logic l);
    sb.push_back({l, d});
    drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({data_out, rd_valid, rd_last, full, empty, frames_ready, err_overflow, err_underflow} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got dout=%02h v=%0b l=%0b f=%0b e=%0b fr=%0d, expected 00 0 0 0 1 0",
               data_out, rd_valid, rd_last, full, empty, frames_ready);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    read_word(8'h90, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_out, rd_valid, rd_last, full, empty, frames_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: got dout=%02h v=%0b l=%0b f=%0b e=%0b fr=%0d, expected 00 0 0 0 1 0",
               data_out, rd_valid, rd_last, full, empty, frames_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      if (i == 3) begin
        checks++;
        if (frames_ready !== 2'd0 || empty !== 1'b1) begin
          errors++;
          $display("FAIL partial_frame: got fr=%0d empty=%0b, expected 0 1", frames_ready, empty);
        end
      end
    end
    idle();
    checks++;
    if (frames_ready !== 2'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL commit_full: got fr=%0d empty=%0b, expected 1 0", frames_ready, empty);
    end
    for (int i = 0; i < 4; i++) read_word(8'(8'h10 + i), i == 3);
    idle();
    wait_drain("full_frame");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_frame_empty: got %0b, expected 1", empty);
    end
  endtask

  task automatic test_short_frame();
    drive(1'b1, 1'b0, 8'hA0, 1'b0);
    drive(1'b1, 1'b1, 8'hA1, 1'b0);
    idle();
    checks++;
    if (frames_ready !== 2'd1) begin
      errors++;
      $display("FAIL short_commit: got fr=%0d, expected 1", frames_ready);
    end
    read_word(8'hA0, 1'b0);
    read_word(8'hA1, 1'b1);
    idle();
    wait_drain("short_frame");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    idle();
    checks++;
    if (full !== 1'b1 || frames_ready !== 2'd2) begin
      errors++;
      $display("FAIL full_flag: got full=%0b fr=%0d, expected 1 2", full, frames_ready);
    end
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    idle();
    checks++;
    if (err_overflow !== EXP_ERR || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got err=%0b full=%0b, expected %0b 1", err_overflow, full, EXP_ERR);
    end
    for (int i = 0; i < 8; i++) begin
      read_word(8'(i), (i == 3) || (i == 7));
      if (i > 0) begin
        checks++;
        if (rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble_%0d: got rd_valid=%0b, expected 1", i, rd_valid);
        end
      end
    end
    idle();
    wait_drain("overflow");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL overflow_empty: got %0b, expected 1", empty);
    end
  endtask

  task automatic test_commit_release();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) read_word(8'(8'h20 + i), 1'b0);
    sb.push_back({1'b1, 8'h23});
    drive(1'b1, 1'b0, 8'h33, 1'b1);
    idle();
    checks++;
    if (frames_ready !== 2'd1) begin
      errors++;
      $display("FAIL commit_release: got fr=%0d, expected 1", frames_ready);
    end
    for (int i = 0; i < 4; i++) read_word(8'(8'h30 + i), i == 3);
    idle();
    wait_drain("commit_release");
  endtask

  task automatic test_underflow_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    checks++;
    if (rd_valid !== 1'b0 || err_underflow !== EXP_ERR) begin
      errors++;
      $display("FAIL underflow: got v=%0b err=%0b, expected 0 %0b", rd_valid, err_underflow, EXP_ERR);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    read_word(8'h40, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || frames_ready !== 2'd0 ||
        err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got v=%0b e=%0b fr=%0d eo=%0b eu=%0b, expected 0 1 0 0 0",
               rd_valid, empty, frames_ready, err_overflow, err_underflow);
    end
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h55 + i), 1'b0);
    for (int i = 0; i < 4; i++) read_word(8'(8'h55 + i), i == 3);
    idle();
    wait_drain("after_reset");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_empty: got %0b, expected 1", empty);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; data_in = 8'h00; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_full_frame();
    test_short_frame();
    test_overflow();
    test_commit_release();
    test_underflow_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
